// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: CSR map, control/status
// bit positions and the sequencer state encoding.
package pio_seq_pkg;

    localparam logic [2:0] CSR_CTRL     = 3'd0;
    localparam logic [2:0] CSR_STATUS   = 3'd1;
    localparam logic [2:0] CSR_PERIOD   = 3'd2;
    localparam logic [2:0] CSR_LENGTH   = 3'd3;
    localparam logic [2:0] CSR_TAB_ADDR = 3'd4;
    localparam logic [2:0] CSR_TAB_DATA = 3'd5;

    localparam int CTRL_RUN_BIT     = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_CLR_ERR_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_IDX_LSB  = 4;
    localparam int STAT_IDX_W    = 3;

    // state    | meaning
    // ST_IDLE  | stopped, waiting for run
    // ST_WRITE | one-cycle PIO write of table[idx]
    // ST_CHECK | one-cycle PIO read-back and compare
    // ST_WAIT  | step period countdown
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pio_pattern_sequencer_if.sv
// Bus bundle for the sequencer: Avalon-MM CSR slave from the HPS bridge and
// the Avalon-MM master towards the PIO slave. The slave modport is the
// sequencer's view, the master modport is the host/PIO side.
interface pio_pattern_sequencer_if;

    logic [2:0]  csr_address;
    logic        csr_chipselect;
    logic        csr_write_n;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;

    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;

    modport slave (
        input  csr_address, csr_chipselect, csr_write_n, csr_writedata,
        output csr_readdata,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata
    );

    modport master (
        output csr_address, csr_chipselect, csr_write_n, csr_writedata,
        input  csr_readdata,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata
    );

endinterface

// File: rtl/pio_seq_table.sv
// Pattern table: DEPTH x DATA_W, one synchronous write port, two asynchronous
// read ports (CSR side and sequencer side). Resets to all-ones so an idle
// table matches the PIO's own reset value.
module pio_seq_table #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     csr_addr,
    output logic [DATA_W-1:0] csr_data,
    input  logic [AW-1:0]     seq_addr,
    output logic [DATA_W-1:0] seq_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage with reset to all-ones and a single write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign csr_data = mem[csr_addr];
    assign seq_data = mem[seq_addr];

endmodule

// File: rtl/pio_pattern_sequencer.sv
// PIO pattern sequencer: steps through a small pattern table, writing each
// entry to a PIO slave, reading it back to verify, then waiting a programmable
// period before the next step. Configured through a 6-word CSR block.
module pio_pattern_sequencer
    import pio_seq_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_pattern_sequencer_if.slave  bus,
    output logic                    busy,
    output logic                    err_irq
);

    localparam int IDX_W = $clog2(DEPTH);

    seq_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  length;
    logic [IDX_W-1:0]  tab_addr;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_load;
    logic [PERIOD_W-1:0] cnt;
    logic              run;
    logic              oneshot;
    logic              err;
    logic              csr_wr;
    logic              ctrl_wr;
    logic              tab_wr;
    logic              mismatch;
    logic [DATA_W-1:0] csr_tab_data;
    logic [DATA_W-1:0] seq_tab_data;
    logic              unused_bits;

    assign csr_wr  = bus.csr_chipselect && !bus.csr_write_n;
    assign ctrl_wr = csr_wr && (bus.csr_address == CSR_CTRL);
    assign tab_wr  = csr_wr && (bus.csr_address == CSR_TAB_DATA);

    // Upper data bits are don't-care on both buses.
    assign unused_bits = ^{bus.csr_writedata, bus.pio_readdata};

    pio_seq_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (tab_wr),
        .wr_addr  (tab_addr),
        .wr_data  (bus.csr_writedata[DATA_W-1:0]),
        .csr_addr (tab_addr),
        .csr_data (csr_tab_data),
        .seq_addr (load_idx),
        .seq_data (seq_tab_data)
    );

    // CSR-owned configuration registers; TAB_ADDR auto-increments on TAB_DATA writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period   <= '0;
            length   <= '1;
            tab_addr <= '0;
        end else if (csr_wr) begin
            case (bus.csr_address)
                CSR_PERIOD:   period   <= bus.csr_writedata[PERIOD_W-1:0];
                CSR_LENGTH:   length   <= bus.csr_writedata[IDX_W-1:0];
                CSR_TAB_ADDR: tab_addr <= bus.csr_writedata[IDX_W-1:0];
                CSR_TAB_DATA: tab_addr <= tab_addr + 1'b1;
                default: ;
            endcase
        end
    end

    // Index the next WRITE will use; the sequencer read port is addressed by it
    // so the write data can be registered on entry to WRITE.
    always_comb begin
        load_idx = idx;
        case (state)
            ST_IDLE: load_idx = '0;
            ST_WAIT: load_idx = (idx >= length) ? '0 : idx + 1'b1;
            default: load_idx = idx;
        endcase
    end

    // PERIOD=0 behaves as PERIOD=1 so WAIT always lasts at least one cycle.
    assign period_load = (period == '0) ? '0 : period - 1'b1;

    // Read-back is compared against the value actually driven in WRITE.
    assign mismatch = (state == ST_CHECK) &&
                      (bus.pio_readdata[DATA_W-1:0] != bus.pio_writedata[DATA_W-1:0]);

    // Sequencer FSM with registered PIO master outputs, run/oneshot and err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            idx                <= '0;
            cnt                <= '0;
            run                <= 1'b0;
            oneshot            <= 1'b0;
            err                <= 1'b0;
            bus.pio_chipselect <= 1'b0;
            bus.pio_write_n    <= 1'b1;
            bus.pio_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state              <= ST_WRITE;
                        idx                <= load_idx;
                        bus.pio_chipselect <= 1'b1;
                        bus.pio_write_n    <= 1'b0;
                        bus.pio_writedata  <= 32'(seq_tab_data);
                    end
                end
                ST_WRITE: begin
                    state           <= ST_CHECK;
                    bus.pio_write_n <= 1'b1;
                end
                ST_CHECK: begin
                    bus.pio_chipselect <= 1'b0;
                    if (run) begin
                        state <= ST_WAIT;
                        cnt   <= period_load;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if ((idx >= length) && oneshot) begin
                        idx   <= '0;
                        run   <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        idx                <= load_idx;
                        state              <= ST_WRITE;
                        bus.pio_chipselect <= 1'b1;
                        bus.pio_write_n    <= 1'b0;
                        bus.pio_writedata  <= 32'(seq_tab_data);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A mismatch in the same cycle as clr_err keeps err set.
            if (ctrl_wr && bus.csr_writedata[CTRL_CLR_ERR_BIT]) begin
                err <= 1'b0;
            end
            if (mismatch) begin
                err <= 1'b1;
            end

            // A host CTRL write overrides the oneshot self-clear.
            if (ctrl_wr) begin
                run     <= bus.csr_writedata[CTRL_RUN_BIT];
                oneshot <= bus.csr_writedata[CTRL_ONESHOT_BIT];
            end
        end
    end

    assign bus.pio_address = 2'b00;
    assign busy            = (state != ST_IDLE);
    assign err_irq         = err;

    // Combinational CSR read mux; CTRL and unmapped offsets read zero.
    always_comb begin
        bus.csr_readdata = '0;
        case (bus.csr_address)
            CSR_STATUS: begin
                bus.csr_readdata[STAT_BUSY_BIT]                = busy;
                bus.csr_readdata[STAT_ERR_BIT]                 = err;
                bus.csr_readdata[STAT_IDX_LSB +: STAT_IDX_W]   = STAT_IDX_W'(idx);
            end
            CSR_PERIOD:   bus.csr_readdata = 32'(period);
            CSR_LENGTH:   bus.csr_readdata = 32'(length);
            CSR_TAB_ADDR: bus.csr_readdata = 32'(tab_addr);
            CSR_TAB_DATA: bus.csr_readdata = 32'(csr_tab_data);
            default: ;
        endcase
    end

endmodule
